fp_cmp_pipe: RTL and testbench
==============================

// Module: fp_cmp_pipe
// PURPOSE
//  Pipelined FP compare/select stage. Sits downstream of the operand read
//  port and wraps the fpCompare condition vector. Decodes a compare opcode
//  into FEQ/FLT/FLE/FCMP/FMIN/FMAX results and raises the IEEE invalid flag
//  that fpCompare leaves at 0. Uses valid/ready handshakes with full
//  backpressure, 2-cycle latency and one result per clock when unstalled.
// PARAMETERS
//  FPWID  64  operand width; EMSB/FMSB come from fpSize.sv
//  TAGW   4   width of the opaque tag carried alongside each operation
// PORTS
//  clk        in   1              clock
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              operation presented
//  in_ready   out  1              stage can accept this cycle
//  in_op      in   3              opcode (encodings in fp_cmp_pkg)
//  in_tag     in   TAGW           passthrough tag
//  a, b       in   FPWID+`EXTRA_BITS  operands, IEEE 754
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
//  out_res    out  FPWID+`EXTRA_BITS  result; boolean ops give 0/1 zero-extended
//  out_tag    out  TAGW           tag of this result
//  out_nv     out  1              invalid-operation exception flag
// BEHAVIOUR
//  - Reset: out_valid=0, out_res=0, out_tag=0, out_nv=0, both stage valids 0.
//    in_ready=1 from the first cycle after reset. An in-flight op is discarded.
//  - S0 register captures op, tag, a and b when in_valid&in_ready. fpCompare
//    sits between S0 and S1. S1 is the output register. Latency is 2 clocks
//    from acceptance to out_valid.
//  - Handshake: s1_adv = !out_valid | out_ready. s0_adv = !s0_valid | s1_adv.
//    in_ready = s0_adv, which is combinational from out_ready. No
//    bubbles: with out_ready held at 1, throughput is 1 op/clk.
//  - out_* stay stable while out_valid & !out_ready.
//  - Condition vector c[4:0] = {unord, mag_lt, le, lt, eq}.
//  - FEQ: res=c[0]. nv=1 only if a or b is an SNaN.
//  - FLT: res=c[1]. nv=1 if c[4].
//  - FLE: res=c[2]. nv=1 if c[4].
//  - FCMP: res=c[4:0] zero-extended. nv=0.
//  - FMIN/FMAX selection:
//    - Neither operand is NaN: select the smaller/larger operand.
//    - -0 vs +0: FMIN returns -0 and FMAX returns +0, whatever the order.
//    - Exactly one NaN: return the other operand.
//    - Both NaN: return the canonical qNaN (sign 0, exponent all 1s,
//      mantissa MSB 1, rest 0).
//    - nv=1 if either operand is an SNaN.
//  - SNaN is defined as exponent all 1s, mantissa nonzero, mantissa MSB 0.
//  - Reserved opcodes: res=0, nv=0, and the op still flows (the tag returns).
//  - When S1 drains and S0 fills in the same cycle, both actions complete.
//  - Simultaneous accept and stall: the op enters S0 only if s0_adv.
// STRUCTURE
//  - fp_cmp_pkg holds:
//    - opcode localparams: FEQ=0, FLT=1, FLE=2, FCMP=3, FMIN=4, FMAX=5,
//      6-7 reserved;
//    - condition-bit index constants CMP_EQ..CMP_UN;
//    - a canonical-qNaN function parameterised by FPWID.
//  - The single sub-module is fpCompare #(FPWID), instantiated on the S0
//    operands. SNaN/zero detection is local logic. Target is about 200 lines.
// TESTING
//  1 FLT a=1.0(3FF0..0) b=2.0(4000..0) -> out_res=1, nv=0, out_valid at
//    the 2nd clk after accept.
//  2 FEQ +0 vs -0 -> res=1. FMIN(+0,-0) -> 8000_0000_0000_0000.
//    FMAX(-0,+0) -> 0.
//  3 FLE a=qNaN(7FF8..0) b=1.0 -> res=0, nv=1. FEQ same operands -> res=0,
//    nv=0. FEQ with SNaN 7FF0..01 -> nv=1.
//  4 FMAX qNaN vs 3.0 -> 4008..0. FMIN SNaN vs SNaN -> 7FF8..0, nv=1.
//  5 Issue 6 back-to-back ops with out_ready=1 -> 6 results on 6 consecutive
//    clks, tags 0..5 in order. Then hold out_ready=0 for 3 clks -> in_ready=0
//    after 2 accepts and out_res stable. Release -> no loss or duplication.
//  6 Assert rst with both stages full -> next clk out_valid=0, in_ready=1.
//    The following op returns with correct tag and no stale result.

Source files
------------

// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the pipelined FP compare/select stage.
//   - Opcode encodings for the compare/select operations (6-7 reserved).
//   - Bit positions inside the fpCompare condition vector.
//   - Format helpers: exponent width per operand width, canonical quiet NaN.
package fp_cmp_pkg;

  // Extra operand bits beyond the IEEE container; none in this format.
  localparam int EXTRA_BITS = 0;

  // Opcodes
  localparam logic [2:0] FEQ  = 3'd0;
  localparam logic [2:0] FLT  = 3'd1;
  localparam logic [2:0] FLE  = 3'd2;
  localparam logic [2:0] FCMP = 3'd3;
  localparam logic [2:0] FMIN = 3'd4;
  localparam logic [2:0] FMAX = 3'd5;

  // Condition vector bit positions: {unord, mag_lt, le, lt, eq}
  localparam int CMP_EQ     = 0;
  localparam int CMP_LT     = 1;
  localparam int CMP_LE     = 2;
  localparam int CMP_MAG_LT = 3;
  localparam int CMP_UN     = 4;

  // Exponent width for the supported IEEE container widths.
  function automatic int exp_bits(input int fpwid);
    case (fpwid)
      16:      return 5;
      32:      return 8;
      80:      return 15;
      128:     return 15;
      default: return 11;
    endcase
  endfunction

  // Canonical quiet NaN for a FPWID-bit operand: sign 0, exponent all ones,
  // mantissa MSB set, remaining mantissa bits clear. Returned right-aligned
  // in a 128-bit vector so callers slice out the width they need.
  function automatic logic [127:0] canon_qnan(input int fpwid);
    logic [127:0] r;
    int lo;
    int hi;
    r  = '0;
    hi = fpwid - 2;                   // exponent MSB
    lo = fpwid - 2 - exp_bits(fpwid); // mantissa MSB
    for (int i = 0; i < 128; i++) begin
      r[i] = (i >= lo) && (i <= hi);
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_cmp_pipe_fpcompare.sv
// fpCompare: purely combinational IEEE 754 comparison of two operands.
// Ports:
//   a, b  in   FPWID  operands
//   o     out  5      condition vector {unord, mag_lt, le, lt, eq}
// All ordered relations (and mag_lt) are forced to 0 when either operand is
// a NaN; +0 and -0 compare equal.
module fpCompare
  import fp_cmp_pkg::*;
#(
  parameter int FPWID = 64
) (
  input  logic [FPWID-1:0] a,
  input  logic [FPWID-1:0] b,
  output logic [4:0]       o
);

  localparam int EB   = exp_bits(FPWID);
  localparam int EMSB = FPWID - 2;
  localparam int FMSB = FPWID - 2 - EB;

  logic a_nan, b_nan, unord, both_zero;
  logic mag_lt_raw, eq, lt;

  assign a_nan     = (&a[EMSB:FMSB+1]) && (|a[FMSB:0]);
  assign b_nan     = (&b[EMSB:FMSB+1]) && (|b[FMSB:0]);
  assign unord     = a_nan | b_nan;
  assign both_zero = ~|a[FPWID-2:0] && ~|b[FPWID-2:0];
  assign mag_lt_raw = a[FPWID-2:0] < b[FPWID-2:0];
  assign eq        = !unord && ((a == b) || both_zero);

  always_comb begin
    lt = 1'b0;
    if (!unord && !both_zero) begin
      if (a[FPWID-1] != b[FPWID-1])
        lt = a[FPWID-1];                       // negative < positive
      else if (!a[FPWID-1])
        lt = mag_lt_raw;
      else
        lt = b[FPWID-2:0] < a[FPWID-2:0];      // both negative: order flips
    end
  end

  assign o = {unord, !unord && mag_lt_raw, lt | eq, lt, eq};

endmodule

// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: two-stage FP compare/select pipeline with valid/ready flow
// control. S0 registers the operation, fpCompare evaluates it, S1 holds the
// decoded result until the consumer takes it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready combinational on out_ready)
//   in_op, in_tag         opcode and opaque tag
//   a, b                  IEEE 754 operands
//   out_valid/out_ready   output handshake
//   out_res, out_tag      result (booleans zero-extended) and its tag
//   out_nv                invalid-operation flag
module fp_cmp_pipe
  import fp_cmp_pkg::*;
#(
  parameter int FPWID = 64,
  parameter int TAGW  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [TAGW-1:0]            in_tag,
  input  logic [FPWID+EXTRA_BITS-1:0] a,
  input  logic [FPWID+EXTRA_BITS-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FPWID+EXTRA_BITS-1:0] out_res,
  output logic [TAGW-1:0]            out_tag,
  output logic                       out_nv
);

  localparam int W    = FPWID + EXTRA_BITS;
  localparam int EB   = exp_bits(FPWID);
  localparam int EMSB = FPWID - 2;
  localparam int FMSB = FPWID - 2 - EB;
  localparam logic [127:0] QNAN_FULL = canon_qnan(FPWID);
  localparam logic [W-1:0] QNAN = W'(QNAN_FULL[FPWID-1:0]);

  // Stage registers
  logic            s0_valid_reg;
  logic [2:0]      s0_op_reg;
  logic [TAGW-1:0] s0_tag_reg;
  logic [W-1:0]    s0_a_reg, s0_b_reg;
  logic            out_valid_reg;
  logic [W-1:0]    out_res_reg;
  logic [TAGW-1:0] out_tag_reg;
  logic            out_nv_reg;

  logic            s0_adv, s1_adv;
  logic [4:0]      cmp;
  logic [W-1:0]    res_next;
  logic            nv_next;

  // Local operand classification
  logic a_nan, b_nan, a_snan, b_snan, both_zero;
  logic sa, sb;

  // S1 can load whenever it is empty or being drained this cycle; S0 can
  // load whenever it is empty or moving into S1.
  assign s1_adv   = !out_valid_reg || out_ready;
  assign s0_adv   = !s0_valid_reg || s1_adv;
  assign in_ready = s0_adv;

  fpCompare #(.FPWID(FPWID)) u_cmp (
    .a (s0_a_reg[FPWID-1:0]),
    .b (s0_b_reg[FPWID-1:0]),
    .o (cmp)
  );

  assign sa        = s0_a_reg[FPWID-1];
  assign sb        = s0_b_reg[FPWID-1];
  assign a_nan     = (&s0_a_reg[EMSB:FMSB+1]) && (|s0_a_reg[FMSB:0]);
  assign b_nan     = (&s0_b_reg[EMSB:FMSB+1]) && (|s0_b_reg[FMSB:0]);
  assign a_snan    = a_nan && !s0_a_reg[FMSB];
  assign b_snan    = b_nan && !s0_b_reg[FMSB];
  assign both_zero = ~|s0_a_reg[FPWID-2:0] && ~|s0_b_reg[FPWID-2:0];

  // Result decode
  always_comb begin
    res_next = '0;
    nv_next  = 1'b0;
    case (s0_op_reg)
      FEQ: begin
        res_next[0] = cmp[CMP_EQ];
        nv_next     = a_snan | b_snan;   // quiet compare: only SNaN signals
      end
      FLT: begin
        res_next[0] = cmp[CMP_LT];
        nv_next     = cmp[CMP_UN];
      end
      FLE: begin
        res_next[0] = cmp[CMP_LE];
        nv_next     = cmp[CMP_UN];
      end
      FCMP: begin
        res_next[4:0] = cmp;
      end
      FMIN, FMAX: begin
        nv_next = a_snan | b_snan;
        if (a_nan && b_nan)
          res_next = QNAN;
        else if (a_nan)
          res_next = s0_b_reg;
        else if (b_nan)
          res_next = s0_a_reg;
        else if (both_zero)
          // Signed zeros compare equal, so pick the sign explicitly:
          // min leans negative, max leans positive.
          res_next = {(s0_op_reg == FMIN) ? (sa | sb) : (sa & sb), {(W-1){1'b0}}};
        else if (s0_op_reg == FMIN)
          res_next = cmp[CMP_LT] ? s0_a_reg : s0_b_reg;
        else
          res_next = cmp[CMP_LT] ? s0_b_reg : s0_a_reg;
      end
      default: begin
        res_next = '0;   // reserved opcodes still carry their tag through
        nv_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_reg  <= 1'b0;
      s0_op_reg     <= '0;
      s0_tag_reg    <= '0;
      s0_a_reg      <= '0;
      s0_b_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_res_reg   <= '0;
      out_tag_reg   <= '0;
      out_nv_reg    <= 1'b0;
    end else begin
      if (s0_adv) begin
        s0_valid_reg <= in_valid;
        if (in_valid) begin
          s0_op_reg  <= in_op;
          s0_tag_reg <= in_tag;
          s0_a_reg   <= a;
          s0_b_reg   <= b;
        end
      end
      if (s1_adv) begin
        out_valid_reg <= s0_valid_reg;
        if (s0_valid_reg) begin
          out_res_reg <= res_next;
          out_tag_reg <= s0_tag_reg;
          out_nv_reg  <= nv_next;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_res   = out_res_reg;
  assign out_tag   = out_tag_reg;
  assign out_nv    = out_nv_reg;

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Self-checking bench for fp_cmp_pipe (FPWID=64, TAGW=4).
module tb_fp_cmp_pipe;
  import fp_cmp_pkg::*;

  localparam logic [63:0] P_ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] P_TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] P_THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] N_3P5   = 64'hC00C_0000_0000_0000;
  localparam logic [63:0] P_ZERO  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] N_ZERO  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] P_INF   = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] N_INF   = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] SNAN    = 64'h7FF0_0000_0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic [63:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;
  logic [3:0]  out_tag;
  logic        out_nv;

  typedef struct packed {
    logic [3:0]  tag;
    logic [63:0] res;
    logic        nv;
  } exp_t;

  exp_t       sb[$];
  int         pop_cyc[$];
  logic [3:0] pop_tag[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         tests_run = 0;
  int         tests_failed = 0;

  fp_cmp_pipe #(.FPWID(64), .TAGW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .a         (op_a),
    .b         (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_nv    (out_nv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every result that transfers is compared with the oldest
  // expectation pushed at acceptance time.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_result tag=%0d res=%h nv=%0b (no result expected)",
                 out_tag, out_res, out_nv);
      end else begin
        mon_e = sb.pop_front();
        if (out_tag !== mon_e.tag || out_res !== mon_e.res || out_nv !== mon_e.nv) begin
          tests_failed++;
          $display("FAIL result got tag=%0d res=%h nv=%0b expected tag=%0d res=%h nv=%0b",
                   out_tag, out_res, out_nv, mon_e.tag, mon_e.res, mon_e.nv);
        end else begin
          $display("[TB] result tag=%0d res=%h nv=%0b ok", out_tag, out_res, out_nv);
        end
      end
      pop_cyc.push_back(cyc);
      pop_tag.push_back(out_tag);
    end
  end

  // Reference model built on real-number comparison of the operands.
  function automatic void model(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic nv);
    logic xn, yn, xs, ys, un, xz, yz;
    real  rx, ry, mx, my;
    xn = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    yn = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
    xs = xn && !x[51];
    ys = yn && !y[51];
    un = xn || yn;
    xz = (x[62:0] == 63'd0);
    yz = (y[62:0] == 63'd0);
    rx = $bitstoreal(x);
    ry = $bitstoreal(y);
    mx = $bitstoreal({1'b0, x[62:0]});
    my = $bitstoreal({1'b0, y[62:0]});
    r  = '0;
    nv = 1'b0;
    case (op)
      3'd0: begin r[0] = !un && (rx == ry); nv = xs || ys; end
      3'd1: begin r[0] = !un && (rx <  ry); nv = un; end
      3'd2: begin r[0] = !un && (rx <= ry); nv = un; end
      3'd3: r[4:0] = {un, !un && (mx < my), !un && (rx <= ry), !un && (rx < ry), !un && (rx == ry)};
      3'd4, 3'd5: begin
        nv = xs || ys;
        if (xn && yn)      r = QNAN;
        else if (xn)       r = y;
        else if (yn)       r = x;
        else if (xz && yz) r = {(op == 3'd4) ? (x[63] | y[63]) : (x[63] & y[63]), 63'd0};
        else if (op == 3'd4) r = (rx < ry) ? x : y;
        else                 r = (rx > ry) ? x : y;
      end
      default: ;
    endcase
  endfunction

  // Present one op and hold it until accepted; returns at posedge+1 after
  // the accepting edge with in_valid still high.
  task automatic issue(input logic [2:0] op, input logic [3:0] tag, input logic [63:0] xa,
                       input logic [63:0] xb, input logic [63:0] xres, input logic xnv);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    op_a     = xa;
    op_b     = xb;
    for (int w = 0; w < 64 && !acc; w++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{tag: tag, res: xres, nv: xnv});
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout tag=%0d in_ready stayed 0, expected 1", tag);
      in_valid = 1'b0;
    end
  endtask

  task automatic issue_m(input logic [2:0] op, input logic [3:0] tag,
                         input logic [63:0] xa, input logic [63:0] xb);
    logic [63:0] r;
    logic        nv;
    model(op, xa, xb, r, nv);
    issue(op, tag, xa, xb, r, nv);
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && sb.size() != 0; w++) begin
      @(posedge clk); #2;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain pending=%0d, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_tag = '0;
    op_a = '0; op_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run += 5;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_res !== 64'd0)  begin tests_failed++; $display("FAIL reset_out_res got %h want 0", out_res); end
    if (out_tag !== 4'd0)   begin tests_failed++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
    if (out_nv !== 1'b0)    begin tests_failed++; $display("FAIL reset_out_nv got %b want 0", out_nv); end
    if (in_ready !== 1'b1)  begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_flt_latency();
    out_ready = 1'b1;
    issue(FLT, 4'd1, P_ONE, P_TWO, 64'd1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_early out_valid got %b want 0", out_valid); end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL latency_2clk out_valid got %b want 1", out_valid); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_signed_zero();
    out_ready = 1'b1;
    issue(FEQ,  4'd2, P_ZERO, N_ZERO, 64'd1, 1'b0);
    issue(FMIN, 4'd3, P_ZERO, N_ZERO, N_ZERO, 1'b0);
    issue(FMAX, 4'd4, N_ZERO, P_ZERO, P_ZERO, 1'b0);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_nan_flags();
    out_ready = 1'b1;
    issue(FLE, 4'd5, QNAN, P_ONE, 64'd0, 1'b1);
    issue(FEQ, 4'd6, QNAN, P_ONE, 64'd0, 1'b0);
    issue(FEQ, 4'd7, SNAN, P_ONE, 64'd0, 1'b1);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_minmax_misc();
    out_ready = 1'b1;
    issue(FMAX, 4'd8,  QNAN, P_THREE, P_THREE, 1'b0);
    issue(FMIN, 4'd9,  SNAN, SNAN, QNAN, 1'b1);
    issue(FMIN, 4'd10, N_3P5, P_TWO, N_3P5, 1'b0);
    issue(FCMP, 4'd11, P_ONE, P_TWO, 64'h0E, 1'b0);
    issue(3'd6, 4'd12, P_ONE, P_TWO, 64'd0, 1'b0);
    issue(3'd7, 4'd13, SNAN, QNAN, 64'd0, 1'b0);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  vo[6];
    logic [63:0] va[6];
    logic [63:0] vb[6];
    vo = '{FLT, FEQ, FLE, FCMP, FMIN, FMAX};
    va = '{N_3P5, P_THREE, P_INF, N_3P5, P_ONE, SNAN};
    vb = '{P_TWO, P_THREE, P_THREE, N_INF, N_ZERO, P_TWO};
    out_ready = 1'b1;
    pop_cyc.delete();
    pop_tag.delete();
    for (int i = 0; i < 6; i++) issue_m(vo[i], 4'(i), va[i], vb[i]);
    in_valid = 1'b0;
    drain();
    tests_run++;
    if (pop_cyc.size() != 6) begin
      tests_failed++;
      $display("FAIL b2b_count got %0d results want 6", pop_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (pop_tag[i] !== 4'(i)) begin
          tests_failed++;
          $display("FAIL b2b_tag_order index %0d got tag %0d want %0d", i, pop_tag[i], i);
        end
      end
      for (int i = 1; i < 6; i++) begin
        tests_run++;
        if (pop_cyc[i] != pop_cyc[i-1] + 1) begin
          tests_failed++;
          $display("FAIL b2b_consecutive index %0d gap %0d clks want 1", i, pop_cyc[i] - pop_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] va[4];
    logic [63:0] vb[4];
    logic [63:0] r;
    logic        nv, have, acc_now;
    logic [63:0] held_res;
    logic [3:0]  held_tag;
    int          k, acc_cnt;
    va = '{P_ONE, P_THREE, N_3P5, P_TWO};
    vb = '{P_TWO, P_ONE, N_ZERO, P_TWO};
    k = 0; acc_cnt = 0; have = 1'b0;
    held_res = '0; held_tag = '0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = FMAX; in_tag = 4'd10; op_a = va[0]; op_b = vb[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc_now = in_ready;
      if (acc_now) begin
        model(in_op, op_a, op_b, r, nv);
        sb.push_back('{tag: in_tag, res: r, nv: nv});
        acc_cnt++;
      end
      if (out_valid) begin
        if (!have) begin
          held_res = out_res; held_tag = out_tag; have = 1'b1;
        end else begin
          tests_run++;
          if (out_res !== held_res || out_tag !== held_tag) begin
            tests_failed++;
            $display("FAIL stall_stable got res=%h tag=%0d want res=%h tag=%0d",
                     out_res, out_tag, held_res, held_tag);
          end
        end
      end
      @(posedge clk); #1;
      if (acc_now && k < 3) begin
        k++;
        in_tag = 4'(10 + k); op_a = va[k]; op_b = vb[k];
      end
    end
    tests_run += 2;
    if (acc_cnt != 2) begin tests_failed++; $display("FAIL stall_accepts got %0d want 2", acc_cnt); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    issue(FLT, 4'd3, P_ONE, P_TWO, 64'd1, 1'b0);
    issue(FLT, 4'd4, P_TWO, P_ONE, 64'd0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    tests_run += 2;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin tests_failed++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    issue(FMAX, 4'd9, P_ONE, P_TWO, P_TWO, 1'b0);
    in_valid = 1'b0;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_flt_latency();
    test_signed_zero();
    test_nan_flags();
    test_minmax_misc();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
